// File: rtl/relu_forward.sv
// relu_forward: vectorised ReLU / leaky-ReLU forward stage on IEEE-754 binary32
// lanes. Positive, zero and NaN lanes bypass the multiplier but travel through
// the same four register stages, so every lane has a fixed four-cycle latency.
module relu_forward #(
  parameter real negative_slope = 0.0,
  parameter int  WIDTH          = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clk_en,
  input  logic [31:0] in_data  [WIDTH-1:0],
  output logic [31:0] out_data [WIDTH-1:0]
);

  // Elaboration-time double -> binary32 conversion, round-to-nearest-even.
  // Values below the binary32 normal range become +0.0.
  function automatic logic [31:0] to_binary32(input logic [63:0] d);
    logic [10:0] de;
    logic [23:0] mant;
    logic [24:0] mant_r;
    logic        rup;
    int          e;
    de = d[62:52];
    if (de == 11'd0) return 32'd0;
    if (de == 11'h7FF) return {d[63], 8'hFF, (d[51:0] != 52'd0) ? 23'h400000 : 23'd0};
    e      = int'(de) - 896;
    mant   = {1'b1, d[51:29]};
    rup    = d[28] & ((|d[27:0]) | mant[0]);
    mant_r = {1'b0, mant} + {24'd0, rup};
    if (mant_r[24]) begin
      mant_r = mant_r >> 1;
      e      = e + 1;
    end
    if (e <= 0) return 32'd0;
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    return {d[63], e[7:0], mant_r[22:0]};
  endfunction

  localparam logic [31:0]        SLOPE_BITS = to_binary32($realtobits(negative_slope));
  localparam logic [7:0]         SLOPE_EXP  = SLOPE_BITS[30:23];
  localparam logic [23:0]        SLOPE_MANT = {1'b1, SLOPE_BITS[22:0]};
  // A subnormal slope is flushed, so it behaves exactly like 0.0.
  localparam logic               SLOPE_ZERO = (SLOPE_EXP == 8'd0);
  localparam logic signed [9:0]  EXP_ADJ    = 10'(SLOPE_EXP) - 10'sd127;

  // Round the normalised 24-bit mantissa of a 48-bit product to nearest-even.
  // Returns {biased exponent (11b, signed), rounded mantissa with hidden bit}.
  function automatic logic [34:0] rne_round(input logic [47:0] prod,
                                            input logic signed [9:0] exp_in);
    logic [23:0] mant;
    logic        guard;
    logic        sticky;
    logic [24:0] mant_r;
    logic [10:0] exp_r;
    exp_r = {exp_in[9], exp_in};
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_r  = exp_r + 11'd1;
    end else begin
      mant   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    mant_r = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    if (mant_r[24]) begin
      mant_r = mant_r >> 1;
      exp_r  = exp_r + 11'd1;
    end
    return {exp_r, mant_r[23:0]};
  endfunction

  // Pack a negative rounded result: underflow flushes to +0.0, overflow is -inf.
  function automatic logic [31:0] saturate_pack(input logic [34:0] r);
    logic signed [10:0] e;
    e = signed'(r[34:24]);
    if (e <= 11'sd0) return 32'h0000_0000;
    if (e >= 11'sd255) return 32'hFF80_0000;
    return {1'b1, e[7:0], r[22:0]};
  endfunction

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [31:0]       x;
    logic              is_mul;
    logic [31:0]       fixed_res;

    logic              mul_p0;
    logic [31:0]       fix_p0;
    logic [7:0]        exp_p0;
    logic [23:0]       man_p0;

    logic              mul_p1;
    logic [31:0]       fix_p1;
    logic signed [9:0] exp_p1;
    logic [47:0]       prod_p1;

    logic              mul_p2;
    logic [31:0]       fix_p2;
    logic [31:0]       rnd_p2;

    logic [31:0]       out_p3;

    assign x = in_data[i];

    // Classify the lane: NaN/positive pass through, zeros/flushes give +0.0, -inf is fixed.
    always_comb begin
      is_mul    = 1'b0;
      fixed_res = x;
      if (x[30:23] == 8'hFF && x[22:0] != 23'd0) begin
        fixed_res = x;
      end else if (x[30:0] == 31'd0) begin
        fixed_res = 32'h0000_0000;
      end else if (!x[31]) begin
        fixed_res = x;
      end else if (x[30:23] == 8'd0 || SLOPE_ZERO) begin
        fixed_res = 32'h0000_0000;
      end else if (x[30:23] == 8'hFF) begin
        fixed_res = 32'hFF80_0000;
      end else begin
        is_mul    = 1'b1;
        fixed_res = 32'h0000_0000;
      end
    end

    // Stage 1: register the unpacked operand and its classification.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        mul_p0 <= 1'b0;
        fix_p0 <= '0;
        exp_p0 <= '0;
        man_p0 <= '0;
      end else if (clk_en) begin
        mul_p0 <= is_mul;
        fix_p0 <= fixed_res;
        exp_p0 <= x[30:23];
        man_p0 <= {1'b1, x[22:0]};
      end
    end

    // Stage 2: 24x24 mantissa product and biased exponent sum.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        mul_p1  <= 1'b0;
        fix_p1  <= '0;
        exp_p1  <= '0;
        prod_p1 <= '0;
      end else if (clk_en) begin
        mul_p1  <= mul_p0;
        fix_p1  <= fix_p0;
        exp_p1  <= signed'({2'b00, exp_p0}) + EXP_ADJ;
        prod_p1 <= {24'd0, man_p0} * {24'd0, SLOPE_MANT};
      end
    end

    // Stage 3: normalise, round and saturate the product.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        mul_p2 <= 1'b0;
        fix_p2 <= '0;
        rnd_p2 <= '0;
      end else if (clk_en) begin
        mul_p2 <= mul_p1;
        fix_p2 <= fix_p1;
        rnd_p2 <= saturate_pack(rne_round(prod_p1, exp_p1));
      end
    end

    // Stage 4: select the multiplier or bypass result and register the output.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        out_p3 <= '0;
      end else if (clk_en) begin
        out_p3 <= mul_p2 ? rnd_p2 : fix_p2;
      end
    end

    assign out_data[i] = out_p3;
  end

endmodule

// File: tb/tb_relu_forward.sv
// tb_relu_forward: three relu_forward instances (slopes 0.0, 0.5, 0.01) share one
// input stream and are compared against a real-arithmetic reference model.
module tb_relu_forward;
  localparam int  W  = 8;
  localparam real S1 = 0.5;
  localparam real S2 = 0.01;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clk_en = 1'b0;
  logic [31:0] in_data [W-1:0];
  logic [31:0] out0 [W-1:0];
  logic [31:0] out1 [W-1:0];
  logic [31:0] out2 [W-1:0];

  int total = 0;
  int bad   = 0;
  logic [31:0]     slope_bits [3];
  logic [W*32-1:0] hist [$];

  relu_forward #(.WIDTH(W)) dut0 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .in_data(in_data), .out_data(out0));
  relu_forward #(.negative_slope(S1), .WIDTH(W)) dut1 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .in_data(in_data), .out_data(out1));
  relu_forward #(.negative_slope(S2), .WIDTH(W)) dut2 (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .in_data(in_data), .out_data(out2));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int k = 0; k < n; k++) r = r * 2.0;
    else        for (int k = 0; k < -n; k++) r = r / 2.0;
    return r;
  endfunction

  // binary32 bits -> real value (subnormals read as zero, as the datapath flushes them)
  function automatic real s2r(input logic [31:0] b);
    real v;
    if (b[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(int'(b[22:0])) / 8388608.0) * pow2(int'(b[30:23]) - 127);
    return b[31] ? -v : v;
  endfunction

  // real -> binary32, round-to-nearest-even, results below the normal range flush to +0.0
  function automatic logic [31:0] r2f(input real v);
    logic   s;
    real    a, m, fl;
    int     e;
    longint mi;
    if (v == 0.0) return 32'd0;
    s = (v < 0.0);
    a = s ? -v : v;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m  = a * 8388608.0;
    fl = $floor(m);
    mi = longint'(fl);
    if ((m - fl) > 0.5 || ((m - fl) == 0.5 && mi[0])) mi++;
    if (mi == 64'd16777216) begin mi = 64'd8388608; e++; end
    if (e < -126) return 32'd0;
    if (e > 127) return {s, 8'hFF, 23'd0};
    return {s, 8'(e + 127), mi[22:0]};
  endfunction

  function automatic logic [31:0] ref_lane(input logic [31:0] x, input logic [31:0] sl);
    if (x[30:23] == 8'hFF && x[22:0] != 23'd0) return x;
    if (x[30:0] == 31'd0) return 32'd0;
    if (!x[31]) return x;
    if (x[30:23] == 8'd0) return 32'd0;
    if (sl[30:23] == 8'd0) return 32'd0;
    if (x[30:23] == 8'hFF) return 32'hFF80_0000;
    return r2f(s2r(x) * s2r(sl));
  endfunction

  function automatic logic [31:0] dut_out(input int d, input int l);
    case (d)
      0:       return out0[l];
      1:       return out1[l];
      default: return out2[l];
    endcase
  endfunction

  function automatic logic [W*32-1:0] pack_in();
    logic [W*32-1:0] v;
    for (int l = 0; l < W; l++) v[l*32 +: 32] = in_data[l];
    return v;
  endfunction

  function automatic logic [31:0] rand_val();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 9))
      0:       return {s, 31'd0};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, 23'($urandom_range(1, 8388607))};
      3:       return {s, 8'd0, 23'($urandom)};
      4:       return {1'b1, 8'($urandom_range(1, 12)), 23'($urandom)};
      default: return $urandom;
    endcase
  endfunction

  task automatic set_all(input logic [31:0] v);
    for (int l = 0; l < W; l++) in_data[l] = v;
  endtask

  task automatic set_rand();
    for (int l = 0; l < W; l++) in_data[l] = rand_val();
  endtask

  // One clock: update the latency model from what the DUT saw at the edge, then compare.
  task automatic tick();
    logic [W*32-1:0] oldest;
    logic [31:0]     exp;
    @(posedge clk);
    #1;
    if (!reset_n) hist.delete();
    else if (clk_en) begin
      hist.push_back(pack_in());
      if (hist.size() > 4) void'(hist.pop_front());
    end
    oldest = (hist.size() == 4) ? hist[0] : '0;
    for (int d = 0; d < 3; d++)
      for (int l = 0; l < W; l++) begin
        exp = (hist.size() == 4) ? ref_lane(oldest[l*32 +: 32], slope_bits[d]) : 32'd0;
        check($sformatf("pipe d%0d l%0d", d, l), dut_out(d, l), exp);
      end
  endtask

  logic [31:0] vec_a  [W] = '{32'h3F800000, 32'hBF800000, 32'h00000000, 32'h80000000,
                               32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'hC2C80000};
  logic [31:0] exp_a  [W] = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000,
                               32'h7F800000, 32'h00000000, 32'h7FC00000, 32'h00000000};
  logic [31:0] vec_b  [4] = '{32'hC0000000, 32'hBF800000, 32'h40400000, 32'hC2C80000};
  logic [31:0] exp_b1 [4] = '{32'hBF800000, 32'hBF000000, 32'h40400000, 32'hC2480000};
  logic [31:0] snap   [W];

  initial begin
    slope_bits[0] = r2f(0.0);
    slope_bits[1] = r2f(S1);
    slope_bits[2] = r2f(S2);

    // reset with live input and enable: reset wins
    set_all(32'h3F800000);
    reset_n = 1'b0;
    clk_en  = 1'b1;
    tick();
    tick();
    for (int l = 0; l < W; l++) check($sformatf("reset l%0d", l), out0[l], 32'h0);

    // release: first sample emerges after the fourth enabled edge
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    check("latency3", out0[0], 32'h0);
    tick();
    for (int l = 0; l < W; l++) check($sformatf("latency4 l%0d", l), out0[l], 32'h3F800000);

    // special values with slope 0.0
    for (int l = 0; l < W; l++) in_data[l] = vec_a[l];
    repeat (4) tick();
    for (int l = 0; l < W; l++) check($sformatf("slope0 l%0d", l), out0[l], exp_a[l]);

    // slopes 0.5 and 0.01 on negative normals
    set_all(32'h0);
    for (int l = 0; l < 4; l++) in_data[l] = vec_b[l];
    repeat (4) tick();
    for (int l = 0; l < 4; l++) check($sformatf("slope0p5 l%0d", l), out1[l], exp_b1[l]);
    check("slope0p01 m100", out2[3], 32'hBF800000);
    check("slope0p01 m1",   out2[1], 32'hBC23D70A);

    // random stream with a three-cycle enable drop in the middle
    for (int n = 0; n < 4000; n++) begin
      if (n == 2000) begin
        for (int l = 0; l < W; l++) snap[l] = out1[l];
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
          set_rand();
          tick();
          for (int l = 0; l < W; l++) check($sformatf("hold c%0d l%0d", k, l), out1[l], snap[l]);
        end
        clk_en = 1'b1;
      end
      set_rand();
      tick();
    end

    // reset mid-stream, then refill
    reset_n = 1'b0;
    set_rand();
    tick();
    reset_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      set_rand();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
